// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the unified-memory arbiter: FSM state encoding,
//   requester port ids, latency-counter width and the round-robin
//   winner selection used in the IDLE state.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    _ARB_IDLE  = 2'd0,
    _ARB_ISSUE = 2'd1,
    _ARB_WAIT  = 2'd2,
    _ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    _ARB_CPU = 1'b0,
    _ARB_DBG = 1'b1
  } arb_port_e;

  // Wide enough to hold the largest supported read latency (8).
  localparam int unsigned CNT_W = 4;

  // A lone requester always wins; on a tie the port not granted last wins.
  function automatic arb_port_e arb_pick(input logic      cpu_req,
                                         input logic      dbg_req,
                                         input arb_port_e last_grant);
    arb_port_e win;
    if (cpu_req && dbg_req) begin
      if (last_grant == _ARB_CPU) win = _ARB_DBG;
      else                        win = _ARB_CPU;
    end else if (cpu_req) begin
      win = _ARB_CPU;
    end else begin
      win = _ARB_DBG;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one unified instruction/data memory between the CPU datapath
//   and a debug/loader port. Requests are level-held until a one-cycle
//   acknowledge; read data is returned through a per-port holding register.
//
// Ports
//   clk, nrst                  clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata      CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack         CPU read-data holding register, done pulse
//   dbg_*                      same as cpu_*, for the debug port
//   mem_en/we/addr/wdata       memory access strobe and command (0 when idle)
//   mem_rdata                  memory read data, valid MEM_LAT cycles after issue
//   busy                       high whenever the arbiter is not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e       state_q, state_d;
  arb_port_e        port_q, port_d;
  arb_port_e        last_q, last_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= _ARB_IDLE;
      port_q      <= _ARB_CPU;
      last_q      <= _ARB_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      _ARB_IDLE: begin
        // Requests are only looked at here; the winner's command is latched
        // so later changes on the request lines cannot disturb the access.
        if (cpu_req || dbg_req) begin
          port_d = arb_pick(cpu_req, dbg_req, last_q);
          if (port_d == _ARB_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          state_d = _ARB_ISSUE;
        end
      end
      _ARB_ISSUE: begin
        if (we_q) begin
          state_d = _ARB_DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = _ARB_WAIT;
        end
      end
      _ARB_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Counter value 1 marks the cycle in which mem_rdata is valid.
        if (cnt_q == CNT_W'(1)) begin
          if (port_q == _ARB_DBG) dbg_rdata_d = mem_rdata;
          else                    cpu_rdata_d = mem_rdata;
          state_d = _ARB_DONE;
        end
      end
      _ARB_DONE: begin
        last_d  = port_q;
        state_d = _ARB_IDLE;
      end
      default: state_d = _ARB_IDLE;
    endcase
  end

  assign mem_en    = (state_q == _ARB_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign cpu_ack   = (state_q == _ARB_DONE) && (port_q == _ARB_CPU);
  assign dbg_ack   = (state_q == _ARB_DONE) && (port_q == _ARB_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != _ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A MEM_LAT=1 instance is driven by a
//   table of directed transaction groups and by random groups whose expected
//   ack cycles and read data come from a transaction-level model; a MEM_LAT=4
//   instance covers the long-latency timing.
module tb_mem_arbiter;

  localparam int LAT = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    int               ncpu;
    int               ndbg;
    txn_t [1:0]       c;
    txn_t [1:0]       d;
    logic [1:0][31:0] ca;   // expected ack cycle per transaction
    logic [1:0][31:0] da;
    logic [1:0][31:0] cr;   // expected rdata at that ack
    logic [1:0][31:0] dr;
    logic [31:0]      ch;   // rdata held on entry
    logic [31:0]      dh;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;

  logic        cpu_req4 = 0, cpu_we4 = 0, dbg_req4 = 0, dbg_we4 = 0;
  logic [31:0] cpu_addr4 = '0, cpu_wdata4 = '0, dbg_addr4 = '0, dbg_wdata4 = '0;
  logic [31:0] cpu_rdata4, dbg_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic        cpu_ack4, dbg_ack4, mem_en4, mem_we4, busy4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req4), .cpu_we(cpu_we4), .cpu_addr(cpu_addr4), .cpu_wdata(cpu_wdata4),
    .cpu_rdata(cpu_rdata4), .cpu_ack(cpu_ack4),
    .dbg_req(dbg_req4), .dbg_we(dbg_we4), .dbg_addr(dbg_addr4), .dbg_wdata(dbg_wdata4),
    .dbg_rdata(dbg_rdata4), .dbg_ack(dbg_ack4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4)
  );

  // Memories: read data is valid for exactly one cycle, junk otherwise.
  logic [31:0] mem1 [256];
  logic [31:0] m1_rd;
  logic [31:0] mem4 [16];
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) m1_rd <= mem1[mem_addr[7:0]];
    else                   m1_rd <= $urandom;
  end
  assign mem_rdata = m1_rd;

  always @(posedge clk) begin
    if (mem_en4 && mem_we4) mem4[mem_addr4[3:0]] <= mem_wdata4;
    if (mem_en4 && !mem_we4) p4[0] <= mem4[mem_addr4[3:0]];
    else                     p4[0] <= $urandom;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_rdata4 = p4[3];

  // Reference model state.
  logic [31:0] m_mem [256];
  logic [31:0] m_crd, m_drd;
  bit          m_last_dbg;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t rd(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    return t;
  endfunction

  function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic vec_t mkv(input int nc, input txn_t c0, input txn_t c1,
                               input int nd, input txn_t d0, input txn_t d1,
                               input int ca0, input int ca1, input int da0, input int da1,
                               input logic [31:0] cr0, input logic [31:0] cr1,
                               input logic [31:0] dr0, input logic [31:0] dr1,
                               input logic [31:0] ch, input logic [31:0] dh);
    vec_t v;
    v.ncpu = nc; v.ndbg = nd;
    v.c[0] = c0; v.c[1] = c1; v.d[0] = d0; v.d[1] = d1;
    v.ca[0] = 32'(ca0); v.ca[1] = 32'(ca1); v.da[0] = 32'(da0); v.da[1] = 32'(da1);
    v.cr[0] = cr0; v.cr[1] = cr1; v.dr[0] = dr0; v.dr[1] = dr1;
    v.ch = ch; v.dh = dh;
    return v;
  endfunction

  // Transaction-level model: each arbitration point picks a winner by the
  // round-robin rule, the winner occupies the memory for 2 (write) or 2+LAT
  // (read) cycles, the next arbitration point follows one cycle after its ack.
  function automatic void predict(inout vec_t v);
    int t, ci, di, cfree, dfree, dur;
    bit c_rdy, d_rdy, gd;
    txn_t x;
    t = 0; ci = 0; di = 0; cfree = 0; dfree = 0;
    v.ch = m_crd; v.dh = m_drd;
    while (ci < v.ncpu || di < v.ndbg) begin
      c_rdy = (ci < v.ncpu) && (cfree <= t);
      d_rdy = (di < v.ndbg) && (dfree <= t);
      if (!c_rdy && !d_rdy) begin
        t++;
        continue;
      end
      gd  = d_rdy && (!c_rdy || !m_last_dbg);
      x   = gd ? v.d[di] : v.c[ci];
      dur = x.we ? 2 : 2 + LAT;
      if (x.we)    m_mem[x.addr[7:0]] = x.wdata;
      else if (gd) m_drd = m_mem[x.addr[7:0]];
      else         m_crd = m_mem[x.addr[7:0]];
      if (gd) begin
        v.da[di] = 32'(t + dur); v.dr[di] = m_drd; di++; dfree = t + dur + 1;
      end else begin
        v.ca[ci] = 32'(t + dur); v.cr[ci] = m_crd; ci++; cfree = t + dur + 1;
      end
      m_last_dbg = gd;
      t = t + dur + 1;
    end
  endfunction

  function automatic int issue_cyc(input txn_t t, input logic [31:0] ack);
    return int'(ack) - (t.we ? 1 : 1 + LAT);
  endfunction

  task automatic drive_cpu(input txn_t t);
    cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
  endtask

  task automatic drive_dbg(input txn_t t);
    dbg_req = 1'b1; dbg_we = t.we; dbg_addr = t.addr; dbg_wdata = t.wdata;
  endtask

  // Applies one transaction group starting in an IDLE cycle (cycle 0); a port
  // with a further transaction replaces its request in the cycle after ack.
  task automatic run_vec(input vec_t v);
    int ci, di;
    bit cadv, dadv, hit, cexp, dexp, bexp;
    logic [31:0] ch, dh;
    ci = 0; di = 0; ch = v.ch; dh = v.dh;
    @(posedge clk); #1;
    if (v.ncpu > 0) drive_cpu(v.c[0]);
    if (v.ndbg > 0) drive_dbg(v.d[0]);
    for (int cyc = 0; cyc < 64 && (ci < v.ncpu || di < v.ndbg); cyc++) begin
      @(negedge clk);
      cadv = 0; dadv = 0;
      if (mem_en) begin
        hit = 0;
        if (ci < v.ncpu && issue_cyc(v.c[ci], v.ca[ci]) == cyc) begin
          chk("bus_cpu", 96'({mem_we, mem_addr, mem_wdata}),
              96'({v.c[ci].we, v.c[ci].addr, v.c[ci].we ? v.c[ci].wdata : cpu_wdata}));
          hit = 1;
        end
        if (di < v.ndbg && issue_cyc(v.d[di], v.da[di]) == cyc) begin
          chk("bus_dbg", 96'({mem_we, mem_addr, mem_wdata}),
              96'({v.d[di].we, v.d[di].addr, v.d[di].we ? v.d[di].wdata : dbg_wdata}));
          hit = 1;
        end
        if (!hit) chk("mem_en", 96'(mem_en), 96'(0));
      end else begin
        chk("bus_idle", 96'({mem_we, mem_addr, mem_wdata}), 96'(0));
      end
      bexp = (ci < v.ncpu && cyc >= issue_cyc(v.c[ci], v.ca[ci]) && cyc <= int'(v.ca[ci])) ||
             (di < v.ndbg && cyc >= issue_cyc(v.d[di], v.da[di]) && cyc <= int'(v.da[di]));
      chk("busy", 96'(busy), 96'(bexp));
      cexp = (ci < v.ncpu) && (cyc == int'(v.ca[ci]));
      dexp = (di < v.ndbg) && (cyc == int'(v.da[di]));
      chk("cpu_ack", 96'(cpu_ack), 96'(cexp));
      chk("dbg_ack", 96'(dbg_ack), 96'(dexp));
      if (cpu_ack && ci < v.ncpu) begin ch = v.cr[ci]; ci++; cadv = 1; end
      if (dbg_ack && di < v.ndbg) begin dh = v.dr[di]; di++; dadv = 1; end
      chk("cpu_rdata", 96'(cpu_rdata), 96'(ch));
      chk("dbg_rdata", 96'(dbg_rdata), 96'(dh));
      @(posedge clk); #1;
      if (cadv) begin
        if (ci < v.ncpu) drive_cpu(v.c[ci]);
        else             cpu_req = 1'b0;
      end
      if (dadv) begin
        if (di < v.ndbg) drive_dbg(v.d[di]);
        else             dbg_req = 1'b0;
      end
    end
    chk("all_acked", 96'({ci, di}), 96'({v.ncpu, v.ndbg}));
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we        = 1'($urandom_range(0, 1));
    t.addr      = $urandom;
    t.addr[7:0] = 8'($urandom_range(96, 111));
    t.wdata     = $urandom;
    return t;
  endfunction

  vec_t tbl [8];
  vec_t v, tmp;
  txn_t none;

  initial begin
    none = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'hC0DE_0000 | 32'(i);
    m_mem[8'h10] = 32'hDEAD_BEEF;
    m_mem[8'h30] = 32'hAAAA_0000;
    m_mem[8'h40] = 32'h55AA_55AA;
    for (int i = 0; i < 256; i++) mem1[i] = m_mem[i];
    for (int i = 0; i < 16; i++) mem4[i] = '0;
    mem4[4] = 32'h4444_4444;
    m_crd = '0; m_drd = '0; m_last_dbg = 1'b1;

    // Groups run in order from reset; ack cycles are relative to the first request.
    tbl[0] = mkv(1, rd(32'h10), none, 1, rd(32'h20), none, 3, 0, 7, 0,
                 32'hDEADBEEF, 0, 32'hC0DE0020, 0, 0, 0);
    tbl[1] = mkv(0, none, none, 1, wr(32'h20, 32'h12345678), none, 0, 0, 2, 0,
                 0, 0, 32'hC0DE0020, 0, 32'hDEADBEEF, 32'hC0DE0020);
    tbl[2] = mkv(2, rd(32'h10), rd(32'h30), 1, rd(32'h40), none, 3, 11, 7, 0,
                 32'hDEADBEEF, 32'hAAAA0000, 32'h55AA55AA, 0, 32'hDEADBEEF, 32'hC0DE0020);
    tbl[3] = mkv(0, none, none, 1, rd(32'h10), none, 0, 0, 3, 0,
                 0, 0, 32'hDEADBEEF, 0, 32'hAAAA0000, 32'h55AA55AA);
    tbl[4] = mkv(1, rd(32'h20), none, 0, none, none, 3, 0, 0, 0,
                 32'h12345678, 0, 0, 0, 32'hAAAA0000, 32'hDEADBEEF);
    tbl[5] = mkv(1, wr(32'h50, 32'hCAFEF00D), none, 1, wr(32'h50, 32'h0BADF00D), none, 5, 0, 2, 0,
                 32'h12345678, 0, 32'hDEADBEEF, 0, 32'h12345678, 32'hDEADBEEF);
    tbl[6] = mkv(0, none, none, 1, rd(32'h50), none, 0, 0, 3, 0,
                 0, 0, 32'hCAFEF00D, 0, 32'h12345678, 32'hDEADBEEF);
    tbl[7] = mkv(1, wr(32'h60, 32'h600D600D), none, 1, rd(32'h60), none, 2, 0, 6, 0,
                 32'h12345678, 0, 32'h600D600D, 0, 32'h12345678, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 96'({cpu_ack, dbg_ack, mem_en, mem_we, busy, mem_addr, mem_wdata}), 96'(0));
    chk("reset_rdata", 96'({cpu_rdata, dbg_rdata}), 96'(0));
    nrst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      tmp = tbl[i];
      predict(tmp);
      run_vec(tbl[i]);
    end

    // Reset during WAIT: everything returns to zero at once, no ack follows.
    @(posedge clk); #1;
    drive_cpu(rd(32'h10));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_rst", 96'(busy), 96'(1));
    nrst = 1'b0;
    #1;
    chk("rst_outputs", 96'({cpu_ack, dbg_ack, mem_en, mem_we, busy, mem_addr, mem_wdata}), 96'(0));
    chk("rst_rdata", 96'({cpu_rdata, dbg_rdata}), 96'(0));
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_ack", 96'({cpu_ack, dbg_ack, busy}), 96'(0));
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    m_crd = '0; m_drd = '0; m_last_dbg = 1'b1;
    v = mkv(1, rd(32'h10), none, 0, none, none, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    predict(v);
    run_vec(v);

    for (int n = 0; n < 40; n++) begin
      v = '0;
      v.ncpu = $urandom_range(0, 2);
      v.ndbg = $urandom_range(0, 2);
      if (v.ncpu + v.ndbg == 0) v.ncpu = 1;
      for (int k = 0; k < 2; k++) begin
        v.c[k] = rnd_txn();
        v.d[k] = rnd_txn();
      end
      predict(v);
      run_vec(v);
    end

    // Four-cycle latency read on the second instance.
    @(posedge clk); #1;
    cpu_req4 = 1'b1; cpu_we4 = 1'b0; cpu_addr4 = 32'h4;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      chk("l4_mem_en", 96'(mem_en4), 96'(cyc == 1));
      chk("l4_busy", 96'(busy4), 96'(cyc >= 1 && cyc <= 6));
      chk("l4_ack", 96'({cpu_ack4, dbg_ack4}), 96'({cyc == 6, 1'b0}));
      chk("l4_rdata", 96'(cpu_rdata4), 96'(cyc >= 6 ? 32'h44444444 : 32'h0));
      @(posedge clk); #1;
      if (cyc == 6) cpu_req4 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
